// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder and its 4-bit carry-select slice.
// Build option: SIGNED_OVF_EN (see nibble_serial_adder.sv).
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Ceiling log2; returns 0 for n <= 1, so callers clamp to a minimum width of 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// 4-bit carry-select slice: both carry-in cases are summed in parallel and
// the incoming carry only drives the final select.
module csa
    import nsa_pkg::*;
(
    output logic                cout,
    output logic [NIBBLE_W-1:0] sum,
    input  logic                cin,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b
);

    logic [NIBBLE_W:0] sum_c0;
    logic [NIBBLE_W:0] sum_c1;

    assign sum_c0 = {1'b0, a} + {1'b0, b};
    assign sum_c1 = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, 1'b1};

    assign {cout, sum} = cin ? sum_c1 : sum_c0;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder that feeds one nibble per clock, LSB first, through a single csa slice.
// Build option: define SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef SIGNED_OVF_EN
    output logic                    ovf,
`endif
    output logic [4*NIBBLES-1:0]    sum,
    output logic                    cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = (clog2(NIBBLES) < 1) ? 1 : clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t              state_reg, state_next;
    logic [W-1:0]        a_sh_reg, b_sh_reg, sum_reg;
    logic                carry_reg, cout_reg;
    logic [CNT_W-1:0]    cnt_reg;

    logic                nib_cout;
    logic [NIBBLE_W-1:0] nib_sum;
    logic [W-1:0]        sum_shift;

    csa u_csa (
        .cout (nib_cout),
        .sum  (nib_sum),
        .cin  (carry_reg),
        .a    (a_sh_reg[NIBBLE_W-1:0]),
        .b    (b_sh_reg[NIBBLE_W-1:0])
    );

    // Each new nibble enters at the top, so after NIBBLES shifts nibble 0 sits at the bottom.
    generate
        if (NIBBLES == 1) begin : g_single
            assign sum_shift = nib_sum;
        end else begin : g_multi
            assign sum_shift = {nib_sum, sum_reg[W-1:NIBBLE_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> NIBBLE_W;
                    b_sh_reg  <= b_sh_reg >> NIBBLE_W;
                    sum_reg   <= sum_shift;
                    carry_reg <= nib_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        cout_reg <= nib_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

`ifdef SIGNED_OVF_EN
    logic a_msb_reg, b_msb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            a_msb_reg <= a[W-1];
            b_msb_reg <= b[W-1];
        end
    end

    // Gated by out_valid so the flag reads 0 whenever no result is presented.
    assign ovf = out_valid && (a_msb_reg == b_msb_reg) && (sum_reg[W-1] != a_msb_reg);
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4 main instance, NIBBLES=1 side instance).
// Checks ovf as well when SIGNED_OVF_EN is defined.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0, sum;
    logic         cin = 1'b0, cout;
    logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
    logic [3:0]   a1 = '0, b1 = '0, sum1;
    logic         cin1 = 1'b0, cout1;
`ifdef SIGNED_OVF_EN
    logic         ovf, ovf1;
`endif

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
`ifdef SIGNED_OVF_EN
        .ovf(ovf),
`endif
        .sum(sum), .cout(cout)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
`ifdef SIGNED_OVF_EN
        .ovf(ovf1),
`endif
        .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   rand_phase = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: latency on out_valid rise, stability while stalled, result on handshake.
    logic         ov_prev = 1'b0, or_prev = 1'b0, c_prev = 1'b0;
    logic [W-1:0] s_prev = '0;
    exp_t         mon_e;
    int           mon_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                chk("latency_has_accept", 32'(acc_q.size() > 0), 1);
                if (acc_q.size() > 0) begin
                    mon_acc = acc_q.pop_front();
                    chk("latency", 32'(cyc - mon_acc), N);
                end
            end
            if (ov_prev && !or_prev) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_sum", 32'(sum), 32'(s_prev));
                chk("hold_cout", 32'(cout), 32'(c_prev));
            end
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    $display("result sum=%h cout=%b (expect %h/%b)", sum, cout, mon_e.s, mon_e.c);
                    chk("sum", 32'(sum), 32'(mon_e.s));
                    chk("cout", 32'(cout), 32'(mon_e.c));
`ifdef SIGNED_OVF_EN
                    chk("ovf", 32'(ovf), 32'(mon_e.o));
`endif
                end
            end
            ov_prev = out_valid;
            or_prev = out_ready;
            s_prev  = sum;
            c_prev  = cout;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_phase) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic [W-1:0] es, input logic ec, input logic eo);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; a = ta; b = tb_v; cin = tc;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        chk("accept_timeout", 32'(got), 1);
        if (got) begin
            exp_q.push_back('{es, ec, eo});
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
        chk("drain_timeout", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic op1(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                       input logic [3:0] es, input logic ec);
        in_valid1 = 1'b1; a1 = ta; b1 = tb_v; cin1 = tc;
        @(negedge clk); chk("n1_in_ready", 32'(in_ready1), 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
        @(negedge clk); chk("n1_run_valid", 32'(out_valid1), 0);
        @(negedge clk);
        $display("n1 result sum=%h cout=%b (expect %h/%b)", sum1, cout1, es, ec);
        chk("n1_valid", 32'(out_valid1), 1);
        chk("n1_sum", 32'(sum1), 32'(es));
        chk("n1_cout", 32'(cout1), 32'(ec));
`ifdef SIGNED_OVF_EN
        chk("n1_ovf", 32'(ovf1), 32'((ta[3] == tb_v[3]) && (es[3] != ta[3])));
`endif
        @(posedge clk); #1;
    endtask

    logic [W-1:0] ra, rb, rs;
    logic         rc, rco, ro;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_n1_out_valid", 32'(out_valid1), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain();

        // Stall the consumer and make sure the result holds.
        out_ready = 1'b0;
        op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("hold_reached", 32'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Abort mid-operation.
        op(16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_cout", 32'(cout), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(out_valid), 0);
        end
        @(posedge clk); #1;
        op(16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0);
        drain();

        // Back-to-back with the consumer always ready.
        op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        drain();

        op1(4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
        op1(4'h7, 4'h8, 1'b1, 4'h0, 1'b1);
        op1(4'h3, 4'h4, 1'b0, 4'h7, 1'b0);

        // Random operands and handshake gaps against the arithmetic reference.
        rand_phase = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            {rco, rs} = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            ro = (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]);
            op(ra, rb, rc, rs, rco, ro);
            if (i % 4 == 0) begin
                in_valid = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk("busy_in_ready", 32'(in_ready), 0);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
        end
        rand_phase = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
